// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the signed_mult8 sequencer (mult_seq_ctrl).
package mult_seq_pkg;

    localparam int unsigned MULT_WIDTH = 32'd8;
    localparam int unsigned MULT_RES_W = 32'd16;

    localparam logic MULT_LOAD_A = 1'b0;
    localparam logic MULT_LOAD_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WAIT   = 3'd3,
        CAPT   = 3'd4,
        RESP   = 3'd5
    } state_e;

endpackage

// File: rtl/mult_seq_arb.sv
// Two-requester arbiter: one-hot grant plus grant id.
// Ties go to requester 0 unless MULT_SEQ_RR_EN selects round-robin.
module mult_seq_arb (
`ifdef MULT_SEQ_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output logic       gid
);

    logic tie_pick_s;

`ifdef MULT_SEQ_RR_EN
    logic ptr_r;

    assign tie_pick_s = ptr_r;

    // Pointer moves to the requester that was not just served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (|grant) begin
            ptr_r <= ~gid;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    assign tie_pick_s = 1'b0;
`endif

    // Grant selection; a tie is resolved by tie_pick_s.
    always_comb begin
        grant = 2'b00;
        gid   = 1'b0;
        if (!enable) begin
            grant = 2'b00;
            gid   = 1'b0;
        end else if (valid == 2'b11) begin
            gid   = tie_pick_s;
            grant = tie_pick_s ? 2'b10 : 2'b01;
        end else if (valid[1]) begin
            gid   = 1'b1;
            grant = 2'b10;
        end else if (valid[0]) begin
            gid   = 1'b0;
            grant = 2'b01;
        end else begin
            gid   = 1'b0;
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer and two-port arbiter in front of the shared signed_mult8 multiplier.
// Define MULT_SEQ_RR_EN for round-robin arbitration (default: fixed priority to port 0).
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned RES_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [RES_W-1:0] resp_data,
    output logic [WIDTH-1:0] mult_abin,
    output logic             mult_absel,
    input  logic [RES_W-1:0] mult_res
);

    state_e           state_r;
    state_e           state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] b_next_s;
    logic [WIDTH-1:0] abin_r;
    logic             absel_r;
    logic             gid_r;
    logic             grant_id_s;
    logic             accept_s;
    logic             arb_en_s;
    logic             resp_ready_sel_s;
    logic [1:0]       grant_s;
    logic [1:0]       valid_s;
    logic [1:0]       resp_valid_r;
    logic [RES_W-1:0] data_r;

    // Readies are held low while reset is asserted, not just after it.
    assign arb_en_s         = (state_r == IDLE) && rst_n;
    assign valid_s          = {req1_valid, req0_valid};
    assign accept_s         = |grant_s;
    assign resp_ready_sel_s = gid_r ? resp1_ready : resp0_ready;

    mult_seq_arb u_arb (
`ifdef MULT_SEQ_RR_EN
        .clk    (clk),
        .rst_n  (rst_n),
`endif
        .enable (arb_en_s),
        .valid  (valid_s),
        .grant  (grant_s),
        .gid    (grant_id_s)
    );

    // Operands as they will be after this edge; the bus register needs them early.
    always_comb begin
        a_next_s = a_r;
        b_next_s = b_r;
        if (accept_s) begin
            a_next_s = grant_id_s ? req1_a : req0_a;
            b_next_s = grant_id_s ? req1_b : req0_b;
        end else begin
            a_next_s = a_r;
            b_next_s = b_r;
        end
    end

    // Next-state logic for the load/wait/capture/respond sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = accept_s ? LOAD_A : IDLE;
            LOAD_A:  state_next_s = LOAD_B;
            LOAD_B:  state_next_s = WAIT;
            WAIT:    state_next_s = CAPT;
            CAPT:    state_next_s = RESP;
            RESP:    state_next_s = resp_ready_sel_s ? IDLE : RESP;
            default: state_next_s = IDLE;
        endcase
    end

    // State, operand, result and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            gid_r        <= 1'b0;
            data_r       <= {RES_W{1'b0}};
            resp_valid_r <= 2'b00;
            abin_r       <= {WIDTH{1'b0}};
            absel_r      <= MULT_LOAD_B;
        end else begin
            state_r <= state_next_s;
            a_r     <= a_next_s;
            b_r     <= b_next_s;
            gid_r   <= accept_s ? grant_id_s : gid_r;
            data_r  <= (state_r == CAPT) ? mult_res : data_r;
            if (state_next_s == RESP) begin
                resp_valid_r <= gid_r ? 2'b10 : 2'b01;
            end else begin
                resp_valid_r <= 2'b00;
            end
            // Outside LOAD_A the bus keeps re-writing B, which is harmless.
            if (state_next_s == LOAD_A) begin
                absel_r <= MULT_LOAD_A;
                abin_r  <= a_next_s;
            end else begin
                absel_r <= MULT_LOAD_B;
                abin_r  <= b_next_s;
            end
        end
    end

    assign req0_ready  = grant_s[0];
    assign req1_ready  = grant_s[1];
    assign resp0_valid = resp_valid_r[0];
    assign resp1_valid = resp_valid_r[1];
    assign resp_data   = data_r;
    assign mult_abin   = abin_r;
    assign mult_absel  = absel_r;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed self-checking bench for mult_seq_ctrl with a behavioural signed_mult8 model.
module tb_mult_seq_ctrl;
    import mult_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [15:0] resp_data;
    logic [7:0]  mult_abin;
    logic        mult_absel;
    logic [15:0] mult_res;

    logic signed [7:0]  ma = 8'sd0;
    logic signed [7:0]  mb = 8'sd0;
    logic signed [15:0] mres = 16'sd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Multiplier model: operand registers selected by ABSel, registered product.
    always @(posedge clk) begin
        if (mult_absel == 1'b0) ma <= mult_abin;
        else                    mb <= mult_abin;
        mres <= ma * mb;
    end
    assign mult_res = mres;

    mult_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .mult_abin(mult_abin), .mult_absel(mult_absel),
        .mult_res(mult_res)
    );

    // Raise valid on one port until ready (bounded); returns in the cycle after accept.
    task automatic send(input int port, input logic [7:0] a, input logic [7:0] b,
                        output int waited, output bit ok);
        waited = 0;
        ok = 1'b0;
        if (port == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else           begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        #1;
        while (!ok && waited < 20) begin
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) ok = 1'b1;
            else begin @(posedge clk); #1; waited++; end
        end
        @(posedge clk); #1;
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    // Wait (bounded) for a response on a port; lat counts cycles from accept.
    task automatic wait_resp(input int port, input int max, output int lat,
                             output logic [15:0] data, output bit other_seen);
        lat = 0;
        data = 16'h0000;
        other_seen = 1'b0;
        for (int n = 1; n <= max; n++) begin
            if ((port == 0 && resp1_valid) || (port == 1 && resp0_valid)) other_seen = 1'b1;
            if ((port == 0 && resp0_valid) || (port == 1 && resp1_valid)) begin
                lat = n;
                data = resp_data;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_handshake: got rdy=%b%b vld=%b%b want 0000",
                     req0_ready, req1_ready, resp0_valid, resp1_valid);
        end
        n_cmp++;
        if (resp_data !== 16'h0000 || mult_abin !== 8'h00 || mult_absel !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_outputs: got data=%h abin=%h absel=%b want 0000 00 1",
                     resp_data, mult_abin, mult_absel);
        end
        req0_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int w, lat; bit ok, oth; logic [15:0] d;
        send(0, 8'h05, 8'hFD, w, ok);
        n_cmp++;
        if (!ok || w != 0) begin
            n_bad++; $display("FAIL single_ready: got ok=%0d wait=%0d want 1 0", ok, w);
        end
        wait_resp(0, 12, lat, d, oth);
        n_cmp++;
        if (lat != 5) begin n_bad++; $display("FAIL single_latency: got %0d want 5", lat); end
        n_cmp++;
        if (d !== 16'hFFF1) begin n_bad++; $display("FAIL single_data: got %h want fff1", d); end
        n_cmp++;
        if (oth || resp1_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_resp1: got seen=%0d want 0", oth);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_corner();
        logic [7:0]  va [3] = '{8'h80, 8'h7F, 8'hFF};
        logic [7:0]  vb [3] = '{8'h80, 8'h80, 8'hFF};
        logic [15:0] vp [3] = '{16'h4000, 16'hC080, 16'h0001};
        int w, lat; bit ok, oth; logic [15:0] d;
        for (int i = 0; i < 3; i++) begin
            send(1, va[i], vb[i], w, ok);
            wait_resp(1, 12, lat, d, oth);
            n_cmp++;
            if (!ok || lat != 5 || d !== vp[i] || oth) begin
                n_bad++;
                $display("FAIL corner_%0d: got ok=%0d lat=%0d data=%h other=%0d want 1 5 %h 0",
                         i, ok, lat, d, oth, vp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int w, lat; bit ok, oth; logic [15:0] d;
        send(1, 8'h0C, 8'h0B, w, ok);
        wait_resp(1, 12, lat, d, oth);
        n_cmp++;
        if (lat != 5 || d !== 16'h0084) begin
            n_bad++; $display("FAIL b2b_first: got lat=%0d data=%h want 5 0084", lat, d);
        end
        @(posedge clk); #1;
        send(0, 8'hF6, 8'h03, w, ok);
        n_cmp++;
        if (!ok || w != 0) begin
            n_bad++; $display("FAIL b2b_accept_t6: got ok=%0d wait=%0d want 1 0", ok, w);
        end
        wait_resp(0, 12, lat, d, oth);
        n_cmp++;
        if (lat != 5 || d !== 16'hFFE2) begin
            n_bad++; $display("FAIL b2b_second: got lat=%0d data=%h want 5 ffe2", lat, d);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        int exp_g [3];
        int g, lat; bit oth; logic [15:0] d, ed;
`ifdef MULT_SEQ_RR_EN
        exp_g = '{0, 1, 0};
`else
        exp_g = '{0, 0, 0};
`endif
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h04;
            req1_valid = 1'b1; req1_a = 8'hFE; req1_b = 8'h06;
            #1;
            if (req0_ready && !req1_ready)      g = 0;
            else if (req1_ready && !req0_ready) g = 1;
            else                                g = -1;
            n_cmp++;
            if (g != exp_g[r]) begin
                n_bad++; $display("FAIL arb_round_%0d: got grant %0d want %0d", r, g, exp_g[r]);
            end
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            ed = (g == 1) ? 16'hFFF4 : 16'h000C;
            wait_resp((g == 1) ? 1 : 0, 12, lat, d, oth);
            n_cmp++;
            if (lat != 5 || d !== ed || oth) begin
                n_bad++;
                $display("FAIL arb_resp_%0d: got lat=%0d data=%h other=%0d want 5 %h 0",
                         r, lat, d, oth, ed);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int w, lat; bit ok, oth; logic [15:0] d;
        resp0_ready = 1'b0;
        send(0, 8'h0A, 8'hF6, w, ok);
        wait_resp(0, 12, lat, d, oth);
        n_cmp++;
        if (lat != 5 || d !== 16'hFF9C) begin
            n_bad++; $display("FAIL bp_first: got lat=%0d data=%h want 5 ff9c", lat, d);
        end
        req1_valid = 1'b1; req1_a = 8'h02; req1_b = 8'h03;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (resp0_valid !== 1'b1 || resp_data !== 16'hFF9C ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got vld=%b data=%h rdy=%b%b want 1 ff9c 00",
                         i, resp0_valid, resp_data, req0_ready, req1_ready);
            end
        end
        resp0_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (req1_ready !== 1'b1 || resp0_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: got rdy1=%b vld0=%b want 1 0", req1_ready, resp0_valid);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_resp(1, 12, lat, d, oth);
        n_cmp++;
        if (lat != 5 || d !== 16'h0006) begin
            n_bad++; $display("FAIL bp_next: got lat=%0d data=%h want 5 0006", lat, d);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int w; bit ok, seen;
        send(0, 8'h14, 8'h14, w, ok);
        @(posedge clk); #1;
        n_cmp++;
        if (dut.state_r !== LOAD_B) begin
            n_bad++; $display("FAIL rmid_in_load_b: got state %0d want 2", dut.state_r);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (dut.state_r !== IDLE || {req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000 ||
            mult_absel !== 1'b1 || mult_abin !== 8'h00 || resp_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL rmid_state: got st=%0d rv=%b%b%b%b absel=%b abin=%h data=%h want 0 0000 1 00 0000",
                     dut.state_r, req0_ready, req1_ready, resp0_valid, resp1_valid,
                     mult_absel, mult_abin, resp_data);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (resp0_valid || resp1_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL rmid_no_resp: got response want none"); end
    endtask

    task automatic test_bus();
        int w; bit ok;
        logic       ea;
        logic [7:0] eb;
        send(0, 8'hF9, 8'h09, w, ok);
        for (int n = 1; n <= 5; n++) begin
            ea = (n == 1) ? 1'b0 : 1'b1;
            eb = (n == 1) ? 8'hF9 : 8'h09;
            n_cmp++;
            if (mult_absel !== ea || mult_abin !== eb) begin
                n_bad++;
                $display("FAIL bus_t%0d: got (%b,%h) want (%b,%h)", n, mult_absel, mult_abin, ea, eb);
            end
            if (n < 5) begin @(posedge clk); #1; end
        end
        n_cmp++;
        if (resp0_valid !== 1'b1 || resp_data !== 16'hFFC1) begin
            n_bad++;
            $display("FAIL bus_resp: got vld=%b data=%h want 1 ffc1", resp0_valid, resp_data);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_corner();
        test_back_to_back();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
        test_bus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
